// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, redirect/kill handling, decode handshake.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_REQ   | presenting a fetch request for pc to instruction memory
// S_WAIT  | request accepted, waiting for the response (kill drops it)
// S_HOLD  | instruction registered and offered to decode
// S_FAULT | misaligned redirect seen; no fetching until aligned redirect
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        NextPCSrc,
  input  logic [31:0] BrTarget,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic        redirect;
  logic [31:0] target;
  logic        req_fire;

  assign imem_addr = pc;
  assign req_fire  = imem_req_valid & imem_req_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic bad_redirect;
  assign redirect     = NextPCSrc & ~(|BrTarget[1:0]);
  assign bad_redirect = NextPCSrc & (|BrTarget[1:0]);
  assign target       = BrTarget;
`else
  // Low target bits are ignored: redirects always land word-aligned.
  logic unused_brtarget_lo;
  assign unused_brtarget_lo = ^BrTarget[1:0];
  assign redirect    = NextPCSrc;
  assign target      = {BrTarget[31:2], 2'b00};
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      kill           <= 1'b0;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst_out       <= 32'h0;
      inst_pc        <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_fault    <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
      // An in-flight request must still be drained after leaving FAULT.
      if (bad_redirect) begin
        state          <= S_FAULT;
        fetch_fault    <= 1'b1;
        imem_req_valid <= 1'b0;
        inst_valid     <= 1'b0;
        if (req_fire || (state == S_WAIT && !imem_rsp_valid))
          kill <= 1'b1;
        else if (imem_rsp_valid)
          kill <= 1'b0;
      end else
`endif
      case (state)
        S_REQ: begin
          if (redirect) begin
            pc <= target;
            if (req_fire) begin
              kill           <= 1'b1;
              state          <= S_WAIT;
              imem_req_valid <= 1'b0;
            end else begin
              imem_req_valid <= 1'b1;
            end
          end else if (req_fire) begin
            state          <= S_WAIT;
            imem_req_valid <= 1'b0;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc <= target;
            if (imem_rsp_valid) begin
              kill           <= 1'b0;
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (kill) begin
              kill           <= 1'b0;
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              inst_out   <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc             <= target;
            inst_valid     <= 1'b0;
            state          <= S_REQ;
            imem_req_valid <= 1'b1;
          end else if (inst_ready) begin
            pc             <= pc + 32'd4;
            inst_valid     <= 1'b0;
            state          <= S_REQ;
            imem_req_valid <= 1'b1;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_FAULT: begin
          if (imem_rsp_valid) kill <= 1'b0;
          if (redirect) begin
            pc          <= target;
            fetch_fault <= 1'b0;
            if (kill && !imem_rsp_valid) begin
              state <= S_WAIT;
            end else begin
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected fetch addresses and instructions are queued
// by each scenario and checked as requests are accepted and instructions handed off.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        NextPCSrc;
  logic [31:0] BrTarget;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 1;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_ipc_q[$];
  logic [31:0] cur_pc;

  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .NextPCSrc(NextPCSrc), .BrTarget(BrTarget),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[7:0], a[31:24], a[23:8]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model plus scoreboard: drive at negedge, sample just before the next posedge.
  initial begin
    logic [31:0] e;
    imem_rsp_valid = 1'b0;
    imem_rdata     = 32'h0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rdata     = 32'h0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          imem_rsp_valid = 1'b1;
          imem_rdata     = mdata(pend_addr);
          pend           = 1'b0;
        end
      end
      #4;
      if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
        pend = 1'b1; pend_cnt = mem_lat; pend_addr = imem_addr;
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_err++;
          $display("FAIL req_addr: unexpected request at %h, none expected", imem_addr);
        end else begin
          e = exp_addr_q.pop_front();
          if (imem_addr !== e) begin
            n_err++;
            $display("FAIL req_addr: got %h expected %h", imem_addr, e);
          end
        end
      end
      if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
        n_cmp++;
        if (exp_ipc_q.size() == 0) begin
          n_err++;
          $display("FAIL inst: unexpected handoff pc=%h data=%h", inst_pc, inst_out);
        end else begin
          e = exp_ipc_q.pop_front();
          if (inst_pc !== e || inst_out !== mdata(e)) begin
            n_err++;
            $display("FAIL inst: got pc=%h data=%h expected pc=%h data=%h",
                     inst_pc, inst_out, e, mdata(e));
          end
        end
      end
    end
  end

  task automatic redirect(input logic [31:0] t);
    NextPCSrc = 1'b1;
    BrTarget  = t;
    @(negedge clk);
    NextPCSrc = 1'b0;
  endtask

  task automatic feed(input int budget, output bit ok);
    bit a_ok, i_ok;
    a_ok = 1'b0; i_ok = 1'b0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < budget && !a_ok; i++) begin
      @(negedge clk);
      if (exp_addr_q.size() == 0) a_ok = 1'b1;
    end
    imem_req_ready = 1'b0;
    for (int i = 0; i < budget && !i_ok; i++) begin
      if (exp_ipc_q.size() == 0) i_ok = 1'b1;
      else @(negedge clk);
    end
    ok = a_ok & i_ok;
    if (!ok) begin
      exp_addr_q.delete();
      exp_ipc_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; NextPCSrc = 1'b0; BrTarget = 32'h0;
    imem_req_ready = 1'b0; inst_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_out !== 32'h0 ||
        inst_pc !== 32'h0 || fetch_fault !== 1'b0 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_vals: rv=%b iv=%b out=%h ipc=%h ff=%b addr=%h required 0,0,0,0,0,0",
               imem_req_valid, inst_valid, inst_out, inst_pc, fetch_fault, imem_addr);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release: req_valid=%b before first edge, required 0", imem_req_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL first_req: req_valid=%b addr=%h required 1 and 00000000", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(32'(i * 4));
      exp_ipc_q.push_back(32'(i * 4));
    end
    feed(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL sequential: ok=%b required 1", ok); end
  endtask

  task automatic test_stall();
    bit done;
    done = 1'b0;
    exp_addr_q.push_back(32'hC);
    exp_ipc_q.push_back(32'hC);
    inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (exp_addr_q.size() == 0) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL stall_req: accepted=%b required 1", done); end
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_err++; $display("FAIL latency_wait: inst_valid=%b required 0", inst_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1) begin
      n_err++; $display("FAIL latency: inst_valid=%b required 1", inst_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_out !== mdata(32'hC) || inst_pc !== 32'hC ||
          imem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold: iv=%b out=%h pc=%h rv=%b required 1 %h 0000000c 0",
                 inst_valid, inst_out, inst_pc, imem_req_valid, mdata(32'hC));
      end
    end
    imem_req_ready = 1'b0;
    inst_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (exp_ipc_q.size() == 0) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL stall_release: handed_off=%b required 1", done); end
  endtask

  task automatic test_redirect_wait();
    bit ok, done;
    done = 1'b0;
    mem_lat = 3;
    exp_addr_q.push_back(32'h10);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (exp_addr_q.size() == 0) done = 1'b1;
    end
    imem_req_ready = 1'b0;
    redirect(32'h100);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (inst_valid !== 1'b0) begin
        n_err++; $display("FAIL wait_kill: inst_valid=%b required 0", inst_valid);
      end
      @(negedge clk);
    end
    mem_lat = 1;
    exp_addr_q.push_back(32'h100);
    exp_ipc_q.push_back(32'h100);
    feed(40, ok);
    n_cmp++;
    if (!ok || !done) begin n_err++; $display("FAIL redirect_wait: ok=%b%b required 11", done, ok); end
  endtask

  task automatic test_redirect_rsp();
    bit ok, done;
    done = 1'b0;
    exp_addr_q.push_back(32'h104);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (exp_addr_q.size() == 0) done = 1'b1;
    end
    imem_req_ready = 1'b0;
    redirect(32'h20);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h20 || inst_valid !== 1'b0 || !done) begin
      n_err++;
      $display("FAIL redirect_rsp: rv=%b addr=%h iv=%b required 1 00000020 0",
               imem_req_valid, imem_addr, inst_valid);
    end
    exp_addr_q.push_back(32'h20);
    exp_ipc_q.push_back(32'h20);
    feed(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL redirect_rsp_feed: ok=%b required 1", ok); end
  endtask

  task automatic test_redirect_req();
    redirect(32'h8);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin
      n_err++;
      $display("FAIL redirect_req: rv=%b addr=%h required 1 00000008", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_handoff_redirect();
    bit ok, done;
    done = 1'b0;
    exp_addr_q.push_back(32'h8);
    exp_ipc_q.push_back(32'h8);
    inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (exp_addr_q.size() == 0) imem_req_ready = 1'b0;
      if (inst_valid === 1'b1) done = 1'b1;
    end
    imem_req_ready = 1'b0;
    inst_ready = 1'b1;
    redirect(32'h40);
    n_cmp++;
    if (!done || inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin
      n_err++;
      $display("FAIL handoff_redirect: held=%b iv=%b rv=%b addr=%h required 1 0 1 00000040",
               done, inst_valid, imem_req_valid, imem_addr);
    end
    exp_addr_q.push_back(32'h40);
    exp_ipc_q.push_back(32'h40);
    feed(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL handoff_redirect_feed: ok=%b required 1", ok); end
  endtask

  task automatic test_kill_on_accept();
    bit ok;
    mem_lat = 2;
    exp_addr_q.push_back(32'h44);
    imem_req_ready = 1'b1;
    redirect(32'h80);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (inst_valid !== 1'b0) begin
        n_err++; $display("FAIL accept_kill: inst_valid=%b required 0", inst_valid);
      end
      @(negedge clk);
    end
    mem_lat = 1;
    exp_addr_q.push_back(32'h80);
    exp_ipc_q.push_back(32'h80);
    feed(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL accept_kill_feed: ok=%b required 1", ok); end
  endtask

  task automatic test_wrap();
    bit ok;
    redirect(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_ipc_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    exp_ipc_q.push_back(32'h0);
    feed(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wrap: ok=%b required 1", ok); end
  endtask

  task automatic test_misalign();
    bit ok;
    redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_err++;
        $display("FAIL fault_state: ff=%b rv=%b iv=%b required 1 0 0",
                 fetch_fault, imem_req_valid, inst_valid);
      end
      @(negedge clk);
    end
    imem_req_ready = 1'b0;
    redirect(32'h200);
    n_cmp++;
    if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
      n_err++;
      $display("FAIL fault_exit: ff=%b rv=%b addr=%h required 0 1 00000200",
               fetch_fault, imem_req_valid, imem_addr);
    end
    cur_pc = 32'h200;
`else
    n_cmp++;
    if (fetch_fault !== 1'b0 || imem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL misalign_force: ff=%b addr=%h required 0 00000100", fetch_fault, imem_addr);
    end
    cur_pc = 32'h100;
`endif
    exp_addr_q.push_back(cur_pc);
    exp_ipc_q.push_back(cur_pc);
    feed(40, ok);
    cur_pc = cur_pc + 32'd4;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL misalign_feed: ok=%b required 1", ok); end
  endtask

  task automatic test_reset_midop();
    bit ok, done;
    done = 1'b0;
    mem_lat = 3;
    exp_addr_q.push_back(cur_pc);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (exp_addr_q.size() == 0) done = 1'b1;
    end
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!done || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0 ||
        inst_out !== 32'h0 || inst_pc !== 32'h0 || fetch_fault !== 1'b0) begin
      n_err++;
      $display("FAIL midop_reset: rv=%b iv=%b addr=%h out=%h ipc=%h ff=%b required all 0",
               imem_req_valid, inst_valid, imem_addr, inst_out, inst_pc, fetch_fault);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b0 || imem_addr !== 32'h0) begin
        n_err++;
        $display("FAIL stale_rsp: iv=%b addr=%h required 0 00000000", inst_valid, imem_addr);
      end
    end
    mem_lat = 1;
    exp_addr_q.push_back(32'h0);
    exp_ipc_q.push_back(32'h0);
    feed(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL midop_feed: ok=%b required 1", ok); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_redirect_req();
    test_handoff_redirect();
    test_kill_on_accept();
    test_wrap();
    test_misalign();
    test_reset_midop();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_addr_q.size() != 0 || exp_ipc_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: addr_q=%0d inst_q=%0d required 0 0", exp_addr_q.size(), exp_ipc_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
